mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the rv32i five-stage pipeline, between `exec` and writeback. It takes the exec result, which is an ALU value or an effective address, and performs loads and stores over a single-outstanding req/ack data-memory port. Loads are sign- or zero-extended, and the stage stalls exec while an access is in flight. It drives the `bp_mem_reg`/`bp_mem_val` bypass consumed by `exec`, and the writeback bus.

## Interface
Parameters:
- `ADDR_W`, 32, data-memory byte-address width; `dmem_addr` carries bits `[ADDR_W-1:2]`

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `ex_valid`  in  1  exec presents an instruction this cycle
- `ex_ready`  out  1  stage accepts; exec must hold inputs while low
- `insn_type`  in  4  codebase type code (`L_TYPE`, `S_TYPE`, others pass-through)
- `insn_sub_type`  in  4  `[2:0]` = RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB/SH/SW 000/001/010)
- `ex_val`  in  32  ALU result / effective address
- `store_data`  in  32  rs2 value for stores
- `rd_ex`  in  5  destination register
- `dmem_req`  out  1  access request, held until ack
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  ADDR_W-2  word address
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_ack`  in  1  access complete; `dmem_rdata` valid same cycle
- `dmem_rdata`  in  32  read word
- `wb_valid`  out  1  writeback entry valid (one-cycle pulse per instruction)
- `wb_rd`  out  5  writeback register (0 for stores)
- `wb_val`  out  32  writeback value
- `bp_mem_reg`  out  5  bypass register; 0 = no bypass
- `bp_mem_val`  out  32  bypass value
- `misalign`  out  1  exception pulse (only with `MEM_MISALIGN_TRAP_EN`)

## Operation
- States: IDLE, WAIT. `ex_ready` = (state == IDLE), driven from a flop.
- In IDLE, with `ex_valid` high and a non-memory type: capture `wb_val <= ex_val`, `wb_rd <= rd_ex`, `wb_valid <= 1`. Stay in IDLE.
- In IDLE, with `ex_valid` high and `L_TYPE`/`S_TYPE`: register `dmem_addr = ex_val[ADDR_W-1:2]`, `dmem_we`, `dmem_be` and `dmem_wdata`. Set `dmem_req <= 1` and go to WAIT.
- Byte enables use offset `o = ex_val[1:0]`:
  - Byte access: `1<<o`.
  - Half access: `4'b0011<<(o&2)`.
  - Word access: `4'hF`.
  - `dmem_wdata`: byte replicated ×4, half replicated ×2, word as is.
- In WAIT, `dmem_req` stays high and all `dmem_*` outputs stay stable until `dmem_ack`.
  - On ack: `dmem_req <= 0`, go to IDLE, `wb_valid <= 1`.
  - Load: `wb_rd <= rd`, `wb_val <=` the selected lane of `dmem_rdata`, extended per funct3.
  - Store: `wb_rd <= 0`.
- Bypass: `bp_mem_reg = wb_valid ? wb_rd : 0`, `bp_mem_val = wb_val`. It is 0 throughout WAIT, so exec never forwards an unfinished load.
- `wb_valid` is low in every cycle where no instruction completes.
- `dmem_ack` seen while in IDLE is ignored.
- Funct3 011/110/111 on a memory type: treated as LW/SW.

## Timing
- Reset (`rst_n` low at an edge) puts the stage in IDLE and clears every output: `ex_ready=1` once the state is IDLE; all other outputs 0.
- Reset during WAIT abandons the access. `dmem_req` is 0 in the next cycle, and a late ack is ignored.
- Non-memory latency: 1 cycle (accept at edge N, `wb_valid` in cycle N+1). Throughput is 1 per cycle.
- Memory access latency: 1 + k cycles, where k ≥ 1 is the number of WAIT cycles up to and including the ack cycle. `dmem_req` first appears in cycle N+1, and `wb_valid` appears in the cycle after the ack.
  - Minimum load-to-writeback is 2 cycles.
  - `ex_ready` is low from N+1 through the ack cycle.
- Back-to-back memory ops: the next op is accepted in the cycle after the ack, so `dmem_req` has at least one low cycle between accesses.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A half access with `o[0]=1`, or a word access with `o≠0`, issues no request.
  - `misalign` pulses for 1 cycle (N+1), with `wb_valid=1` and `wb_rd=0`. The stage stays in IDLE.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied 0.
  - Low offset bits are masked to natural alignment (half: `o&2`, word: 0) and the access proceeds.

## Test plan
- ADD result: `ex_val=0x1234`, `rd_ex=5` → next cycle `wb_valid=1`, `wb_rd=5`, `wb_val=0x1234`, `bp_mem_reg=5`.
- LB at `0x103`, rdata `0x80FF_FF7F`, ack after 3 cycles → `dmem_be=4'b1000`, `ex_ready` low for 3 cycles, `wb_val=0xFFFF_FF80`. The LBU variant gives `0x0000_0080`.
- SH at `0x202`, `store_data=0xDEAD_BEEF` → `dmem_we=1`, `dmem_be=4'b1100`, `dmem_wdata=0xBEEF_BEEF`, then `wb_valid=1` with `wb_rd=0`.
- LW with ack held off 5 cycles → `bp_mem_reg=0` and all `dmem_*` stable through WAIT; `wb_val=rdata` after ack.
- Reset asserted in WAIT, then ack → `dmem_req=0` after reset, no `wb_valid`, stray ack ignored.
- LW at `0x101`: with `MEM_MISALIGN_TRAP_EN`, `misalign=1` and no `dmem_req`. Without it, the request goes to word address `0x40` with `dmem_be=4'hF`.

Source files
------------

// File: rtl/mem_stage.sv
// rv32i memory-access stage: single-outstanding req/ack loads/stores, writeback and bypass.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into a misalign trap.
module mem_stage #(
  parameter int         ADDR_W = 32,
  parameter logic [3:0] L_TYPE = 4'd1,
  parameter logic [3:0] S_TYPE = 4'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        insn_type,
  input  logic [3:0]        insn_sub_type,
  input  logic [31:0]       ex_val,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd_ex,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-3:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_val,
  output logic [4:0]        bp_mem_reg,
  output logic [31:0]       bp_mem_val,
  output logic              misalign
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            r_state;
  logic              r_ex_ready;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [ADDR_W-3:0] r_dmem_addr;
  logic [3:0]        r_dmem_be;
  logic [31:0]       r_dmem_wdata;
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic [31:0]       r_wb_val;
  logic              r_misalign;
  logic [4:0]        r_acc_rd;
  logic [1:0]        r_acc_off;
  logic              r_acc_half;
  logic              r_acc_word;
  logic              r_acc_uns;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_half;
  logic        w_word;
  logic        w_trap;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [15:0] w_lane;
  logic [31:0] w_ld_val;
  logic        w_unused;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    w_is_load  = (insn_type == L_TYPE);
    w_is_store = (insn_type == S_TYPE);
    w_is_mem   = w_is_load | w_is_store;
    // funct3[1:0]: 00 byte, 01 half, 1x word (covers 011/110/111).
    w_half     = (insn_sub_type[1:0] == 2'b01);
    w_word     = insn_sub_type[1];
    w_off      = w_word ? 2'b00 : (w_half ? {ex_val[1], 1'b0} : ex_val[1:0]);
    w_be       = w_word ? 4'hF : (w_half ? (4'b0011 << w_off) : (4'b0001 << w_off));
    w_wdata    = w_word ? store_data
               : (w_half ? {2{store_data[15:0]}} : {4{store_data[7:0]}});
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = w_is_mem & ((w_half & ex_val[0]) | (w_word & (ex_val[1:0] != 2'b00)));
`else
  assign w_trap = 1'b0;
`endif

  assign w_unused = insn_sub_type[3];

  // Offset is already naturally aligned, so one shift selects byte or half lanes.
  always_comb begin
    w_lane = 16'(dmem_rdata >> {r_acc_off, 3'b000});
    if (r_acc_word)
      w_ld_val = dmem_rdata;
    else if (r_acc_half)
      w_ld_val = r_acc_uns ? {16'h0000, w_lane} : {{16{w_lane[15]}}, w_lane};
    else
      w_ld_val = r_acc_uns ? {24'h000000, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ex_ready   <= 1'b1;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_be    <= 4'h0;
      r_dmem_wdata <= 32'h0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_val     <= 32'h0;
      r_misalign   <= 1'b0;
      r_acc_rd     <= 5'd0;
      r_acc_off    <= 2'b00;
      r_acc_half   <= 1'b0;
      r_acc_word   <= 1'b0;
      r_acc_uns    <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ex_valid) begin
            if (w_trap) begin
              r_misalign <= 1'b1;
              r_wb_valid <= 1'b1;
              r_wb_rd    <= 5'd0;
              r_wb_val   <= 32'h0;
            end else if (w_is_mem) begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= w_is_store;
              r_dmem_addr  <= ex_val[ADDR_W-1:2];
              r_dmem_be    <= w_be;
              r_dmem_wdata <= w_wdata;
              r_acc_rd     <= w_is_store ? 5'd0 : rd_ex;
              r_acc_off    <= w_off;
              r_acc_half   <= w_half;
              r_acc_word   <= w_word;
              r_acc_uns    <= insn_sub_type[2];
              r_ex_ready   <= 1'b0;
              r_state      <= WAIT;
            end else begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= rd_ex;
              r_wb_val   <= ex_val;
            end
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_ex_ready <= 1'b1;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_acc_rd;
            if (!r_dmem_we)
              r_wb_val <= w_ld_val;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ex_ready   = r_ex_ready;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_be    = r_dmem_be;
  assign dmem_wdata = r_dmem_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_val     = r_wb_val;
  assign bp_mem_reg = r_wb_valid ? r_wb_rd : 5'd0;
  assign bp_mem_val = r_wb_val;
  assign misalign   = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized ops, byte-level memory reference model,
// a random-latency memory responder and a cycle-level protocol monitor.
module tb_mem_stage;

  localparam logic [3:0] T_LOAD    = 4'd1;
  localparam logic [3:0] T_STORE   = 4'd2;
  localparam int         MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [3:0]  insn_type = 4'd0;
  logic [3:0]  insn_sub_type = 4'd0;
  logic [31:0] ex_val = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd_ex = 5'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic [4:0]  bp_mem_reg;
  logic [31:0] bp_mem_val;
  logic        misalign;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .L_TYPE(T_LOAD), .S_TYPE(T_STORE)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .insn_type(insn_type), .insn_sub_type(insn_sub_type), .ex_val(ex_val),
    .store_data(store_data), .rd_ex(rd_ex), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_val(wb_val), .bp_mem_reg(bp_mem_reg), .bp_mem_val(bp_mem_val), .misalign(misalign)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    bit          val_known;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_exp_t;

  wb_exp_t     exp_wb[$];
  acc_exp_t    exp_acc[$];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] dev_mem [MEM_BYTES/4];

  int checks = 0;
  int errors = 0;
  int force_k = 0;
  bit stray_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic finish_sim;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_word(input int byte_addr, input logic [31:0] w);
    for (int j = 0; j < 4; j++) ref_mem[byte_addr + j] = w[8*j +: 8];
    dev_mem[byte_addr / 4] = w;
  endtask

  // Push the architectural expectation, then present the op until it is accepted.
  task automatic issue(input logic [3:0] t, input logic [2:0] f3, input logic [31:0] v,
                       input logic [31:0] sd, input logic [4:0] rd);
    wb_exp_t  w;
    acc_exp_t a;
    int n, ea, waited;
    logic [31:0] x;
    if (t == T_LOAD || t == T_STORE) begin
      n  = nbytes(f3);
      ea = int'(v) & ~(n - 1);
      a.we = (t == T_STORE);
      a.addr = v[31:2];
      a.be = 4'h0;
      a.wdata = 32'h0;
      for (int i = 0; i < n; i++) a.be[(ea % 4) + i] = 1'b1;
      for (int i = 0; i < 4; i++) a.wdata[8*i +: 8] = sd[8*(i % n) +: 8];
      if (t == T_STORE) begin
        for (int j = 0; j < n; j++) ref_mem[ea + j] = sd[8*j +: 8];
        w.rd = 5'd0; w.val = 32'h0; w.val_known = 1'b0;
      end else begin
        x = 32'h0;
        for (int j = 0; j < n; j++) x[8*j +: 8] = ref_mem[ea + j];
        if (!f3[2] && n < 4 && x[8*n - 1]) x = x | (32'hFFFF_FFFF << (8 * n));
        w.rd = rd; w.val = x; w.val_known = 1'b1;
      end
      exp_acc.push_back(a);
    end else begin
      w.rd = rd; w.val = v; w.val_known = 1'b1;
    end
    exp_wb.push_back(w);
    ex_valid = 1'b1;
    insn_type = t;
    insn_sub_type = {1'b0, f3};
    ex_val = v;
    store_data = sd;
    rd_ex = rd;
    waited = 0;
    forever begin
      @(negedge clk);
      if (ex_ready) break;
      waited++;
      if (waited > 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: ex_ready stayed 0 for %0d cycles, required 1", waited);
        finish_sim();
      end
    end
    tick();
    ex_valid = 1'b0;
  endtask

  // Memory responder: random ack latency, checks the request against the expected access every WAIT cycle.
  initial begin
    int remaining;
    acc_exp_t cur;
    int idx;
    remaining = -1;
    cur.we = 1'b0; cur.addr = '0; cur.be = 4'h0; cur.wdata = 32'h0;
    forever begin
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      if (!dmem_req) begin
        remaining = -1;
        dmem_ack = stray_ack;
      end else begin
        if (remaining < 0) begin
          remaining = (force_k > 0) ? force_k - 1 : $urandom_range(0, 3);
          force_k = 0;
          if (exp_acc.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: dmem_req=1 with no access expected");
          end else begin
            cur = exp_acc.pop_front();
          end
        end
        check("dmem_we", {31'b0, dmem_we}, {31'b0, cur.we});
        check("dmem_addr", {2'b0, dmem_addr}, {2'b0, cur.addr});
        check("dmem_be", {28'b0, dmem_be}, {28'b0, cur.be});
        check("dmem_wdata", dmem_wdata, cur.wdata);
        if (remaining == 0) begin
          idx = int'(dmem_addr % 30'(MEM_BYTES / 4));
          dmem_ack = 1'b1;
          dmem_rdata = dev_mem[idx];
          if (dmem_we)
            for (int i = 0; i < 4; i++)
              if (dmem_be[i]) dev_mem[idx][8*i +: 8] = dmem_wdata[8*i +: 8];
        end else begin
          remaining--;
        end
      end
    end
  end

  // Monitor: cycle-level handshake expectations plus in-order writeback scoreboard.
  initial begin
    bit busy;
    bit wb_due;
    bit is_mem;
    wb_exp_t e;
    busy = 1'b0;
    wb_due = 1'b0;
    forever begin
      @(negedge clk);
      check("ex_ready", {31'b0, ex_ready}, {31'b0, !busy});
      check("dmem_req_state", {31'b0, dmem_req}, {31'b0, busy});
      check("wb_valid", {31'b0, wb_valid}, {31'b0, wb_due});
      check("misalign", {31'b0, misalign}, 32'h0);
      if (wb_valid) begin
        if (exp_wb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: wb_valid=1 rd=%0d with nothing outstanding", wb_rd);
        end else begin
          e = exp_wb.pop_front();
          check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
          check("bp_mem_reg", {27'b0, bp_mem_reg}, {27'b0, e.rd});
          if (e.val_known) begin
            check("wb_val", wb_val, e.val);
            check("bp_mem_val", bp_mem_val, e.val);
          end
        end
      end else begin
        check("bp_mem_reg_idle", {27'b0, bp_mem_reg}, 32'h0);
      end
      is_mem = (insn_type == T_LOAD) || (insn_type == T_STORE);
      wb_due = (ex_valid && ex_ready && !is_mem) || (dmem_req && dmem_ack);
      if (ex_valid && ex_ready && is_mem) busy = 1'b1;
      if (dmem_req && dmem_ack) busy = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
        wb_due = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    checks++; errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  initial begin
    logic [2:0] st_f3 [6];
    logic [3:0] t;
    logic [2:0] f3;
    logic [31:0] v;
    int kind;
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < MEM_BYTES / 4; i++)
      dev_mem[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};

    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    check("rst_ex_ready", {31'b0, ex_ready}, 32'h1);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
    check("rst_dmem_be", {28'b0, dmem_be}, 32'h0);
    check("rst_dmem_addr", {2'b0, dmem_addr}, 32'h0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    check("rst_wb_val", wb_val, 32'h0);
    check("rst_bp_mem_reg", {27'b0, bp_mem_reg}, 32'h0);
    tick();
    rst_n = 1'b1;
    idle(1);

    // Directed cases
    issue(4'd0, 3'd0, 32'h0000_1234, 32'h0, 5'd5);
    set_word(32'h100, 32'h80FF_FF7F);
    force_k = 3;
    issue(T_LOAD, 3'b000, 32'h103, 32'h0, 5'd7);
    force_k = 3;
    issue(T_LOAD, 3'b100, 32'h103, 32'h0, 5'd8);
    issue(T_STORE, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd9);
    force_k = 5;
    issue(T_LOAD, 3'b010, 32'h200, 32'h0, 5'd10);
    issue(T_LOAD, 3'b010, 32'h101, 32'h0, 5'd11);
    idle(6);

    // Reset while an access is outstanding, then a stray ack in IDLE
    force_k = 30;
    issue(T_LOAD, 3'b010, 32'h300, 32'h0, 5'd12);
    idle(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_wb.delete();
    stray_ack = 1'b1;
    idle(3);
    stray_ack = 1'b0;
    idle(2);

    // Randomized mix
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        t = 4'($urandom_range(3, 15));
        f3 = 3'($urandom);
        v = $urandom;
      end else if (kind == 1) begin
        t = T_LOAD;
        f3 = 3'($urandom);
        v = 32'($urandom_range(0, MEM_BYTES - 1));
      end else begin
        t = T_STORE;
        f3 = st_f3[$urandom_range(0, 5)];
        v = 32'($urandom_range(0, MEM_BYTES - 1));
      end
      issue(t, f3, v, $urandom, 5'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(10);
    check("wb_queue_drained", exp_wb.size(), 32'h0);
    check("acc_queue_drained", exp_acc.size(), 32'h0);
    finish_sim();
  end

endmodule
